// File: rtl/keycode_decoder_if.sv
// Keycode decoder bus: HID keycode word, frame tick and board busy in; command strobe out.
interface keycode_decoder_if;
  logic [31:0] keycode;
  logic        frame_clk_rising_edge;
  logic        BOARD_BUSY;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [2:0]  held_dir;

  modport master (
    output keycode, frame_clk_rising_edge, BOARD_BUSY,
    input  cmd_valid, cmd, held_dir
  );

  modport slave (
    input  keycode, frame_clk_rising_edge, BOARD_BUSY,
    output cmd_valid, cmd, held_dir
  );
endinterface

// File: rtl/keycode_decoder.sv
// Per-player keycode decoder: press-edge detect, DAS/ARR auto-repeat on left/right/down,
// one-deep pending queue per action, priority issue gated by BOARD_BUSY.
module keycode_decoder #(
  parameter logic [7:0] KEY_LEFT   = 8'h04,
  parameter logic [7:0] KEY_RIGHT  = 8'h07,
  parameter logic [7:0] KEY_DOWN   = 8'h16,
  parameter logic [7:0] KEY_ROT_L  = 8'h14,
  parameter logic [7:0] KEY_ROT_R  = 8'h08,
  parameter logic [7:0] KEY_HOLD   = 8'h06,
  parameter int         DAS_DELAY  = 10,
  parameter int         ARR_PERIOD = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  keycode_decoder_if.slave   bus
);
  localparam int NA = 6;
  localparam int ND = 3;
  localparam logic [5:0] DAS6   = 6'(DAS_DELAY);
  localparam logic [5:0] RELOAD = 6'(DAS_DELAY - ARR_PERIOD);

  // Action index a maps to command code a+1.
  localparam logic [NA-1:0][7:0] KEYS = {KEY_HOLD, KEY_ROT_R, KEY_ROT_L,
                                         KEY_DOWN, KEY_RIGHT, KEY_LEFT};

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} das_t;

  logic [31:0]   kc_q;
  logic [NA-1:0] hit_raw, hit, prev_hit, press, rep, pending, pending_nxt, issue_oh;
  logic [2:0]    issue_code;
  logic          lr_conflict;

  for (genvar a = 0; a < NA; a++) begin : g_match
    assign hit_raw[a] = (kc_q[7:0]   == KEYS[a]) | (kc_q[15:8]  == KEYS[a]) |
                        (kc_q[23:16] == KEYS[a]) | (kc_q[31:24] == KEYS[a]);
  end

  // Left and right together cancel each other out.
  assign lr_conflict = hit_raw[0] & hit_raw[1];
  assign hit   = {hit_raw[5:2], hit_raw[1:0] & {2{~lr_conflict}}};
  assign press = hit & ~prev_hit;

  for (genvar d = 0; d < ND; d++) begin : g_das
    das_t       state, state_nxt;
    logic [5:0] cnt, cnt_nxt, inc;
    logic       rep_d;

    assign inc    = cnt + 6'd1;
    assign rep[d] = rep_d;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // Press beats a coincident frame tick; release drops straight back to IDLE.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rep_d     = 1'b0;
      if (!hit[d]) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (press[d]) begin
        state_nxt = DELAY;
        cnt_nxt   = '0;
      end else if (bus.frame_clk_rising_edge) begin
        if (inc == DAS6) begin
          rep_d     = 1'b1;
          cnt_nxt   = RELOAD;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = inc;
        end
      end
    end
  end

  assign rep[NA-1:ND] = '0;

  // Priority: rot_l > rot_r > left > right > down > hold.
  always_comb begin
    issue_oh   = '0;
    issue_code = 3'd0;
    if (!bus.BOARD_BUSY) begin
      if      (pending[3]) begin issue_oh[3] = 1'b1; issue_code = 3'd4; end
      else if (pending[4]) begin issue_oh[4] = 1'b1; issue_code = 3'd5; end
      else if (pending[0]) begin issue_oh[0] = 1'b1; issue_code = 3'd1; end
      else if (pending[1]) begin issue_oh[1] = 1'b1; issue_code = 3'd2; end
      else if (pending[2]) begin issue_oh[2] = 1'b1; issue_code = 3'd3; end
      else if (pending[5]) begin issue_oh[5] = 1'b1; issue_code = 3'd6; end
    end
  end

  // Set wins over clear so a repeat landing on its own issue cycle is kept.
  assign pending_nxt = (pending & ~issue_oh) | press | rep;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      kc_q          <= '0;
      prev_hit      <= '0;
      pending       <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd       <= 3'd0;
    end else begin
      kc_q          <= bus.keycode;
      prev_hit      <= hit;
      pending       <= pending_nxt;
      bus.cmd_valid <= |issue_oh;
      if (|issue_oh) bus.cmd <= issue_code;
    end
  end

  assign bus.held_dir = hit[2:0];
endmodule
